// File: rtl/wb_rr_arbiter2_pkg.sv
// Shared types and constants for the two-master round-robin Wishbone arbiter.
package wb_rr_arbiter2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN0  = 2'd1,
        ST_OWN1  = 2'd2,
        ST_ABORT = 2'd3
    } arb_state_e;

    // Width of the per-transfer slave wait counter.
    localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/wb_rr_arbiter2_if.sv
// Bundle of the two master ports and the shared slave port around the arbiter.
interface wb_rr_arbiter2_if #(
    parameter int ADR_W = 2
);

    // Handshake: a transfer is issued in a cycle with cyc & stb & !stall and is
    // completed by exactly one of ack/err/rty; cyc held high keeps bus ownership.
    logic             m0_cyc, m0_stb, m0_we;
    logic [ADR_W-1:0] m0_adr;
    logic [3:0]       m0_sel;
    logic [31:0]      m0_wdat;
    logic             m0_ack, m0_err, m0_rty, m0_stall;
    logic [31:0]      m0_rdat;

    logic             m1_cyc, m1_stb, m1_we;
    logic [ADR_W-1:0] m1_adr;
    logic [3:0]       m1_sel;
    logic [31:0]      m1_wdat;
    logic             m1_ack, m1_err, m1_rty, m1_stall;
    logic [31:0]      m1_rdat;

    logic             s_cyc, s_stb, s_we;
    logic [ADR_W-1:0] s_adr;
    logic [3:0]       s_sel;
    logic [31:0]      s_wdat;
    logic             s_ack, s_err, s_rty, s_stall;
    logic [31:0]      s_rdat;

    modport master (
        output m0_cyc, m0_stb, m0_we, m0_adr, m0_sel, m0_wdat,
        output m1_cyc, m1_stb, m1_we, m1_adr, m1_sel, m1_wdat,
        input  m0_ack, m0_err, m0_rty, m0_stall, m0_rdat,
        input  m1_ack, m1_err, m1_rty, m1_stall, m1_rdat
    );

    modport slave (
        input  s_cyc, s_stb, s_we, s_adr, s_sel, s_wdat,
        output s_ack, s_err, s_rty, s_stall, s_rdat
    );

endinterface

// File: rtl/wb_rr_arbiter2.sv
// Two-master round-robin Wishbone arbiter with a slave-response timeout.
// The owner's bus is passed through combinationally; the other master is stalled.
module wb_rr_arbiter2
    import wb_rr_arbiter2_pkg::*;
#(
    parameter int ADR_W   = 2,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,

    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [3:0]       m0_sel_i,
    input  logic [31:0]      m0_dat_i,
    output logic             m0_ack_o,
    output logic             m0_err_o,
    output logic             m0_rty_o,
    output logic             m0_stall_o,
    output logic [31:0]      m0_dat_o,

    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [3:0]       m1_sel_i,
    input  logic [31:0]      m1_dat_i,
    output logic             m1_ack_o,
    output logic             m1_err_o,
    output logic             m1_rty_o,
    output logic             m1_stall_o,
    output logic [31:0]      m1_dat_o,

    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [3:0]       s_sel_o,
    output logic [31:0]      s_dat_o,
    input  logic             s_ack_i,
    input  logic             s_err_i,
    input  logic             s_rty_i,
    input  logic             s_stall_i,
    input  logic [31:0]      s_dat_i,

    output logic [1:0]       grant_o,
    output logic             timeout_o,
    output arb_state_e       state_o
);

    localparam logic [WAIT_CNT_W:0] TIMEOUT_V = TIMEOUT[WAIT_CNT_W:0];

    arb_state_e            state_q, state_d;
    logic                  last_q, last_d;
    logic                  abort_owner_q, abort_owner_d;
    logic                  pend_q, pend_d;
    logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;

    logic                  own0, own1, owning;
    logic                  own_cyc, own_stb;
    logic                  resp, waiting, hit;
    logic [WAIT_CNT_W:0]   cnt_inc;

    assign own0    = (state_q == ST_OWN0);
    assign own1    = (state_q == ST_OWN1);
    assign owning  = own0 | own1;
    assign own_cyc = own1 ? m1_cyc_i : m0_cyc_i;
    assign own_stb = own1 ? m1_stb_i : m0_stb_i;
    assign resp    = s_ack_i | s_err_i | s_rty_i;

    // A wait cycle is one where a strobe has been accepted and is still unanswered.
    assign waiting = owning & ((own_stb & ~s_stall_i) | pend_q) & ~resp;
    assign cnt_inc = {1'b0, cnt_q} + {{WAIT_CNT_W{1'b0}}, 1'b1};
    assign hit     = waiting & (cnt_inc == TIMEOUT_V);

    assign state_o = state_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            last_q        <= 1'b1;
            abort_owner_q <= 1'b0;
            pend_q        <= 1'b0;
            cnt_q         <= '0;
        end else begin
            state_q       <= state_d;
            last_q        <= last_d;
            abort_owner_q <= abort_owner_d;
            pend_q        <= pend_d;
            cnt_q         <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        last_d        = last_q;
        abort_owner_d = abort_owner_q;
        pend_d        = pend_q;
        cnt_d         = cnt_q;
        case (state_q)
            ST_IDLE: begin
                pend_d = 1'b0;
                cnt_d  = '0;
                // On a tie the master that was not served last wins.
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_q ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    state_d = ST_OWN0;
                end else if (m1_cyc_i) begin
                    state_d = ST_OWN1;
                end
            end
            ST_OWN0, ST_OWN1: begin
                if (!own_cyc) begin
                    state_d = ST_IDLE;
                    last_d  = own1;
                    pend_d  = 1'b0;
                    cnt_d   = '0;
                end else if (hit) begin
                    state_d       = ST_ABORT;
                    abort_owner_d = own1;
                    pend_d        = 1'b0;
                    cnt_d         = '0;
                end else if (resp) begin
                    pend_d = 1'b0;
                    cnt_d  = '0;
                end else if (waiting) begin
                    pend_d = 1'b1;
                    cnt_d  = cnt_inc[WAIT_CNT_W-1:0];
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        grant_o    = 2'b00;
        timeout_o  = 1'b0;
        s_cyc_o    = 1'b0;
        s_stb_o    = 1'b0;
        s_we_o     = 1'b0;
        s_adr_o    = '0;
        s_sel_o    = 4'h0;
        s_dat_o    = 32'h0;
        m0_ack_o   = 1'b0;
        m0_err_o   = 1'b0;
        m0_rty_o   = 1'b0;
        m0_stall_o = m0_stb_i;
        m0_dat_o   = 32'h0;
        m1_ack_o   = 1'b0;
        m1_err_o   = 1'b0;
        m1_rty_o   = 1'b0;
        m1_stall_o = m1_stb_i;
        m1_dat_o   = 32'h0;
        case (state_q)
            ST_OWN0: begin
                grant_o    = 2'b01;
                s_cyc_o    = m0_cyc_i;
                s_stb_o    = m0_stb_i;
                s_we_o     = m0_we_i;
                s_adr_o    = m0_adr_i;
                s_sel_o    = m0_sel_i;
                s_dat_o    = m0_dat_i;
                m0_ack_o   = s_ack_i;
                m0_err_o   = s_err_i;
                m0_rty_o   = s_rty_i;
                m0_stall_o = s_stall_i;
                m0_dat_o   = s_dat_i;
            end
            ST_OWN1: begin
                grant_o    = 2'b10;
                s_cyc_o    = m1_cyc_i;
                s_stb_o    = m1_stb_i;
                s_we_o     = m1_we_i;
                s_adr_o    = m1_adr_i;
                s_sel_o    = m1_sel_i;
                s_dat_o    = m1_dat_i;
                m1_ack_o   = s_ack_i;
                m1_err_o   = s_err_i;
                m1_rty_o   = s_rty_i;
                m1_stall_o = s_stall_i;
                m1_dat_o   = s_dat_i;
            end
            ST_ABORT: begin
                // Bus already released; only the timed-out master sees the error.
                timeout_o = 1'b1;
                if (abort_owner_q) begin
                    m1_err_o = 1'b1;
                end else begin
                    m0_err_o = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Bench for wb_rr_arbiter2: directed scenarios plus random traffic against a cycle model.
module tb_wb_rr_arbiter2;
  import wb_rr_arbiter2_pkg::*;

  localparam int ADR_W = 2;
  localparam int TMO   = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       timeout;
  arb_state_e state;

  wb_rr_arbiter2_if #(.ADR_W(ADR_W)) bus ();

  wb_rr_arbiter2 #(.ADR_W(ADR_W), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .m0_cyc_i(bus.m0_cyc), .m0_stb_i(bus.m0_stb), .m0_we_i(bus.m0_we),
    .m0_adr_i(bus.m0_adr), .m0_sel_i(bus.m0_sel), .m0_dat_i(bus.m0_wdat),
    .m0_ack_o(bus.m0_ack), .m0_err_o(bus.m0_err), .m0_rty_o(bus.m0_rty),
    .m0_stall_o(bus.m0_stall), .m0_dat_o(bus.m0_rdat),
    .m1_cyc_i(bus.m1_cyc), .m1_stb_i(bus.m1_stb), .m1_we_i(bus.m1_we),
    .m1_adr_i(bus.m1_adr), .m1_sel_i(bus.m1_sel), .m1_dat_i(bus.m1_wdat),
    .m1_ack_o(bus.m1_ack), .m1_err_o(bus.m1_err), .m1_rty_o(bus.m1_rty),
    .m1_stall_o(bus.m1_stall), .m1_dat_o(bus.m1_rdat),
    .s_cyc_o(bus.s_cyc), .s_stb_o(bus.s_stb), .s_we_o(bus.s_we),
    .s_adr_o(bus.s_adr), .s_sel_o(bus.s_sel), .s_dat_o(bus.s_wdat),
    .s_ack_i(bus.s_ack), .s_err_i(bus.s_err), .s_rty_i(bus.s_rty),
    .s_stall_i(bus.s_stall), .s_dat_i(bus.s_rdat),
    .grant_o(grant), .timeout_o(timeout), .state_o(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- counters / checker ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // owner: -1 nobody, 0/1 that master, 2 abort cycle for abort_who
  int md_owner, md_abort_who, md_last, md_waits;
  bit md_pend;

  task automatic model_reset();
    md_owner = -1; md_abort_who = 0; md_last = 1; md_waits = 0; md_pend = 1'b0;
  endtask

  function automatic logic [1:0] resp_kind(input logic [2:0] r);
    if (r[2]) return 2'd1;
    if (r[1]) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic [1:0] exp_grant();
    if (md_owner == 0) return 2'b01;
    if (md_owner == 1) return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic [40:0] exp_sreq();
    if (md_owner == 0) return {bus.m0_cyc, bus.m0_stb, bus.m0_we, bus.m0_adr, bus.m0_sel, bus.m0_wdat};
    if (md_owner == 1) return {bus.m1_cyc, bus.m1_stb, bus.m1_we, bus.m1_adr, bus.m1_sel, bus.m1_wdat};
    return '0;
  endfunction

  function automatic logic [35:0] exp_mresp(input int n);
    logic stb;
    stb = (n == 1) ? bus.m1_stb : bus.m0_stb;
    if (md_owner == n) return {bus.s_ack, bus.s_err, bus.s_rty, bus.s_stall, bus.s_rdat};
    if (md_owner == 2 && md_abort_who == n) return {3'b010, stb, 32'h0};
    return {3'b000, stb, 32'h0};
  endfunction

  task automatic model_advance();
    bit any_resp, accepted, cyc, stb;
    any_resp = bus.s_ack | bus.s_err | bus.s_rty;
    if (md_owner == -1) begin
      md_waits = 0; md_pend = 1'b0;
      if (bus.m0_cyc && bus.m1_cyc) md_owner = (md_last == 1) ? 0 : 1;
      else if (bus.m0_cyc) md_owner = 0;
      else if (bus.m1_cyc) md_owner = 1;
    end else if (md_owner == 2) begin
      md_owner = -1;
    end else begin
      cyc = (md_owner == 1) ? bus.m1_cyc : bus.m0_cyc;
      stb = (md_owner == 1) ? bus.m1_stb : bus.m0_stb;
      accepted = stb && !bus.s_stall;
      if (!cyc) begin
        md_last = md_owner; md_owner = -1; md_waits = 0; md_pend = 1'b0;
      end else if (any_resp) begin
        md_waits = 0; md_pend = 1'b0;
      end else if (accepted || md_pend) begin
        md_waits++; md_pend = 1'b1;
        if (md_waits == TMO) begin
          md_abort_who = md_owner; md_owner = 2; md_waits = 0; md_pend = 1'b0;
        end
      end
    end
  endtask

  // ---------------- scoreboard: response events {master, kind, data} ----------------
  logic [34:0] exp_q[$];

  task automatic sb_push_expected();
    for (int n = 0; n < 2; n++) begin
      if (md_owner == n && (bus.s_ack | bus.s_err | bus.s_rty))
        exp_q.push_back({1'(n), resp_kind({bus.s_ack, bus.s_err, bus.s_rty}), bus.s_rdat});
      else if (md_owner == 2 && md_abort_who == n)
        exp_q.push_back({1'(n), 2'd2, 32'h0});
    end
  endtask

  task automatic sb_observe();
    logic [2:0]  r;
    logic [31:0] d;
    logic [34:0] ev;
    for (int n = 0; n < 2; n++) begin
      r = (n == 1) ? {bus.m1_ack, bus.m1_err, bus.m1_rty} : {bus.m0_ack, bus.m0_err, bus.m0_rty};
      d = (n == 1) ? bus.m1_rdat : bus.m0_rdat;
      if (r != 3'b000) begin
        ev = {1'(n), resp_kind(r), d};
        if (exp_q.size() == 0) check("sb_extra", ev, 0);
        else check("sb_event", ev, exp_q.pop_front());
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called right after a negedge with inputs set; checks, advances model, waits next negedge.
  task automatic step();
    #1;
    check("grant", grant, exp_grant());
    check("timeout", timeout, (md_owner == 2));
    check("s_req", {bus.s_cyc, bus.s_stb, bus.s_we, bus.s_adr, bus.s_sel, bus.s_wdat}, exp_sreq());
    check("m0_resp", {bus.m0_ack, bus.m0_err, bus.m0_rty, bus.m0_stall, bus.m0_rdat}, exp_mresp(0));
    check("m1_resp", {bus.m1_ack, bus.m1_err, bus.m1_rty, bus.m1_stall, bus.m1_rdat}, exp_mresp(1));
    sb_push_expected();
    sb_observe();
    model_advance();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    bus.m0_cyc = 0; bus.m0_stb = 0; bus.m0_we = 0; bus.m0_adr = '0; bus.m0_sel = 4'hF; bus.m0_wdat = 32'h0;
    bus.m1_cyc = 0; bus.m1_stb = 0; bus.m1_we = 0; bus.m1_adr = '0; bus.m1_sel = 4'hF; bus.m1_wdat = 32'h0;
    bus.s_ack = 0; bus.s_err = 0; bus.s_rty = 0; bus.s_stall = 0; bus.s_rdat = 32'h0;
  endtask

  task automatic idle_all();
    clear_inputs();
    step();
    step();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit quiet;
    int r;
    rst = 1'b1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    bus.m0_cyc = 1; bus.m0_stb = 1; bus.m1_cyc = 1;
    bus.s_ack = 1;
    #1;
    check("rst_grant", grant, 2'b00);
    check("rst_timeout", timeout, 1'b0);
    check("rst_s_cyc_stb", {bus.s_cyc, bus.s_stb}, 2'b00);
    check("rst_m_resp", {bus.m0_ack, bus.m0_err, bus.m0_rty, bus.m1_ack, bus.m1_err, bus.m1_rty}, 6'h0);
    check("rst_state", state, ST_IDLE);
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();

    // Simultaneous requests after reset: m0 wins, then m1 after m0 releases.
    bus.m0_cyc = 1; bus.m1_cyc = 1;
    step();
    check("tie_first_grant", grant, 2'b01);
    bus.m0_cyc = 0;
    step();
    step();
    check("tie_second_grant", grant, 2'b10);

    // m1 keeps the bus for three acked writes while m0 is stalled.
    bus.m0_cyc = 1; bus.m0_stb = 1;
    for (int a = 0; a < 3; a++) begin
      bus.m1_stb = 1; bus.m1_we = 1; bus.m1_adr = 2'(a); bus.m1_wdat = 32'h100 + 32'(a);
      bus.s_ack = 1;
      #1;
      check("burst_grant", grant, 2'b10);
      check("burst_m1_ack", bus.m1_ack, 1'b1);
      check("burst_m0_stall", bus.m0_stall, 1'b1);
      check("burst_m0_ack", bus.m0_ack, 1'b0);
      step();
    end

    // m1 leaves; m0 gets the bus and the slave never answers.
    bus.m1_cyc = 0; bus.m1_stb = 0; bus.m1_we = 0; bus.s_ack = 0;
    step();
    step();
    check("tmo_grant", grant, 2'b01);
    for (int i = 0; i < TMO; i++) step();
    check("tmo_pulse", timeout, 1'b1);
    check("tmo_m0_err", bus.m0_err, 1'b1);
    check("tmo_grant_idle", grant, 2'b00);
    step();
    check("tmo_pulse_end", timeout, 1'b0);
    idle_all();

    // Ack on the last allowed wait cycle wins over the timeout.
    bus.m0_cyc = 1;
    step();
    bus.m0_stb = 1;
    for (int i = 0; i < TMO - 1; i++) step();
    bus.s_ack = 1; bus.s_rdat = 32'h1234_5678;
    #1;
    check("late_ack_fwd", bus.m0_ack, 1'b1);
    step();
    bus.s_ack = 0; bus.m0_stb = 0;
    #1;
    check("late_ack_no_tmo", timeout, 1'b0);
    check("late_ack_grant", grant, 2'b01);

    // Read data routed to the owner only.
    bus.m0_stb = 1; bus.m0_we = 0; bus.m0_adr = 2'd2; bus.s_ack = 1; bus.s_rdat = 32'hDEAD_BEEF;
    #1;
    check("rd_m0_dat", bus.m0_rdat, 32'hDEAD_BEEF);
    check("rd_m0_ack", bus.m0_ack, 1'b1);
    check("rd_m1_dat", bus.m1_rdat, 32'h0);
    step();
    idle_all();

    // Reset in the middle of an outstanding transfer.
    bus.m0_cyc = 1;
    step();
    bus.m0_stb = 1;
    step();
    check("pre_rst_grant", grant, 2'b01);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_grant", grant, 2'b00);
    check("mid_rst_s_cyc", bus.s_cyc, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    clear_inputs();
    bus.m1_cyc = 1;
    step();
    check("post_rst_grant", grant, 2'b10);
    idle_all();

    // Random traffic; every third block of cycles the slave goes silent.
    for (int c = 0; c < 3000; c++) begin
      quiet = ((c / 300) % 3) == 2;
      if ($urandom_range(0, 7) == 0) bus.m0_cyc = ~bus.m0_cyc;
      if ($urandom_range(0, 7) == 0) bus.m1_cyc = ~bus.m1_cyc;
      bus.m0_stb = bus.m0_cyc & ($urandom_range(0, 2) != 0);
      bus.m1_stb = bus.m1_cyc & ($urandom_range(0, 2) != 0);
      bus.m0_we = 1'($urandom); bus.m0_adr = 2'($urandom); bus.m0_sel = 4'($urandom); bus.m0_wdat = $urandom;
      bus.m1_we = 1'($urandom); bus.m1_adr = 2'($urandom); bus.m1_sel = 4'($urandom); bus.m1_wdat = $urandom;
      r = $urandom_range(0, 9);
      bus.s_ack   = !quiet && (r < 3);
      bus.s_err   = !quiet && (r == 3);
      bus.s_rty   = !quiet && (r == 4);
      bus.s_stall = ($urandom_range(0, 3) == 0);
      bus.s_rdat  = $urandom;
      step();
    end
    idle_all();

    check("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_rr_arbiter2.md
WB_RR_ARBITER2 -- requirements
Module: wb_rr_arbiter2

Interface
REQ-001 Parameter ADR_W, default 2, meaning the word-address width carried on wb address ports as bits [ADR_W+1:2].
REQ-002 Parameter TIMEOUT, default 255, meaning the maximum number of cycles to wait for a slave ack/err/rty before aborting; legal range 1..65535.
REQ-003 clk_i  in  1  the single clock; all state changes on its rising edge.
REQ-004 rst_i  in  1  reset, asynchronous and active-high.
REQ-005 mN_cyc_i, mN_stb_i, mN_we_i  in  1 each (N=0,1)  master N cycle, strobe and write-enable.
REQ-006 mN_adr_i  in  ADR_W  master N word address; mN_sel_i  in  4  byte selects; mN_dat_i  in  32  write data.
REQ-007 mN_ack_o, mN_err_o, mN_rty_o, mN_stall_o  out  1 each; mN_dat_o  out  32  read data.
REQ-008 s_cyc_o, s_stb_o, s_we_o  out  1; s_adr_o  out  ADR_W; s_sel_o  out  4; s_dat_o  out  32  slave request side.
REQ-009 s_ack_i, s_err_i, s_rty_i, s_stall_i  in  1; s_dat_i  in  32  slave response side.
REQ-010 grant_o  out  2  one-hot current owner, 00 when idle; timeout_o  out  1  single-cycle pulse on abort.

Function
REQ-011 The FSM SHALL have states IDLE, OWN0, OWN1 and ABORT, held in registers.
REQ-012 In IDLE with exactly one mN_cyc_i high, the next state SHALL be OWNN; grant latency is one cycle from cyc to grant_o.
REQ-013 In IDLE with both cyc high, the grant SHALL go to the master not served last; the last-served flag resets to 1, so m0 wins the first tie.
REQ-014 In OWNN, slave request outputs SHALL combinationally mirror master N; s_cyc_o and s_stb_o are 0 in IDLE and ABORT.
REQ-015 In OWNN, s_ack_i/s_err_i/s_rty_i/s_stall_i/s_dat_i SHALL route to master N only; the other master sees ack/err/rty=0, stall=1 while its stb is high, and dat_o=0.
REQ-016 OWNN SHALL return to IDLE on the cycle after mN_cyc_i is sampled low; last-served updates to N on that transition.
REQ-017 Ownership SHALL persist across multiple stb/ack transfers while mN_cyc_i stays high.
REQ-018 A 16-bit wait counter SHALL clear on entering OWNN and on any s_ack_i/s_err_i/s_rty_i, and increment each cycle the owner has an outstanding strobe (accepted, i.e. stb with stall low, without response yet).
REQ-019 When the counter reaches TIMEOUT, the next state SHALL be ABORT; in ABORT, mN_err_o=1 to the owner for exactly one cycle, timeout_o pulses, then the state goes to IDLE.
REQ-020 A slave response arriving in the same cycle the counter reaches TIMEOUT SHALL win: it is forwarded and no abort occurs.
REQ-021 In IDLE, a master dropping cyc before being granted SHALL cancel its request with no slave activity.
REQ-022 Master dropping cyc while its strobe is outstanding SHALL still release ownership per REQ-016; a late slave response is discarded.

Reset
REQ-023 While rst_i is high: state IDLE, grant_o=00, timeout_o=0, counter=0, last-served=1, all mN_ack/err/rty_o=0, s_cyc_o=s_stb_o=0.
REQ-024 Reset asserted mid-transfer SHALL abort immediately; the first grant after release follows REQ-012/013.

Structure
REQ-025 The FSM state enumeration and the width constant for the wait counter SHALL live in the shared cheby package.
REQ-026 The design SHALL be a single module; no sub-module.

Verification
REQ-027 m0 and m1 raise cyc in the same cycle after reset -> grant_o=01 one cycle later; after m0 drops cyc, grant_o=10.
REQ-028 m1 holds cyc and does 3 writes to adr 0,1,2 with slave ack each -> grant_o stays 10 throughout, 3 acks to m1, m0 stall=1 and ack=0 during this.
REQ-029 Slave never acks with TIMEOUT=4 -> after 4 wait cycles, m0_err_o=1 for one cycle, timeout_o=1, grant_o=00.
REQ-030 TIMEOUT=4 and s_ack_i on the 4th wait cycle -> ack forwarded, timeout_o stays 0.
REQ-031 rst_i asserted while grant_o=01 with strobe outstanding -> same cycle grant_o=00, s_cyc_o=0; after release a lone m1 cyc gives grant_o=10.
REQ-032 Read from adr 2 by m0 with s_dat_i=0xDEADBEEF -> m0_dat_o=0xDEADBEEF with m0_ack_o, m1_dat_o=0.
